data_mem_lsu: RTL

//  Load/store unit between the pipeline MEM stage and the 4-lane byte-banked data memory.

---
 rtl/lsu_pkg.sv | 36 +++
 rtl/lsu_load_extend.sv | 38 +++
 rtl/data_mem_lsu.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Size encodings match the pipeline's req_size field.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B    = 2'd0,
        SZ_H    = 2'd1,
        SZ_W    = 2'd2,
        SZ_RSVD = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        STORE     = 2'd2,
        RESP      = 2'd3
    } lsu_state_t;

    localparam logic [3:0] WR_NONE = 4'b0000;
    localparam logic [3:0] WR_B    = 4'b0001;
    localparam logic [3:0] WR_H    = 4'b0011;
    localparam logic [3:0] WR_W    = 4'b1111;

    // Lanes are always filled from lane 0 upward; the address never rotates them.
    function automatic logic [3:0] lane_mask(input lsu_size_t size);
        logic [3:0] mask;
        case (size)
            SZ_B:    mask = WR_B;
            SZ_H:    mask = WR_H;
            SZ_W:    mask = WR_W;
            default: mask = WR_NONE;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-data extension: selects byte/half/word from lane 0 upward
// and sign- or zero-extends to 32 bits.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  lsu_size_t   size,
    input  logic        is_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic sign_s;

    // Extend the selected low-order field of the memory word.
    always_comb begin
        result = 32'd0;
        sign_s = 1'b0;
        case (size)
            SZ_B: begin
                sign_s = rdata[7] & ~is_unsigned;
                result = {{24{sign_s}}, rdata[7:0]};
            end
            SZ_H: begin
                sign_s = rdata[15] & ~is_unsigned;
                result = {{16{sign_s}}, rdata[15:0]};
            end
            SZ_W: begin
                sign_s = 1'b0;
                result = rdata;
            end
            default: begin
                sign_s = 1'b0;
                result = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between the MEM stage and the 4-lane byte-banked data memory:
// one request per handshake, registered memory strobes, read-latency sequencing.
module data_mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS    = 16,
    parameter int RD_LAT       = 1,
    parameter int STRICT_ALIGN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wr,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    lsu_state_t         state_r;
    logic [CNT_W-1:0]   cnt_r;
    lsu_size_t          size_r;
    logic               uns_r;
    logic               resp_valid_r;
    logic               resp_err_r;
    logic [31:0]        resp_rdata_r;
    logic [31:0]        mem_raddr_r;
    logic [31:0]        mem_waddr_r;
    logic [31:0]        mem_wdata_r;
    logic [3:0]         mem_wr_r;

    lsu_size_t          req_size_s;
    logic               range_err_s;
    logic               align_err_s;
    logic               fault_s;
    logic               accept_s;
    logic [31:0]        ext_s;

    assign req_size_s = lsu_size_t'(req_size);
    assign req_ready  = (state_r == IDLE) || (state_r == RESP);
    assign accept_s   = req_valid && req_ready;

    // Classify a request as faulting: out of range, reserved size, or misaligned.
    always_comb begin
        range_err_s = (req_addr >> ADDR_BITS) != 32'd0;
        align_err_s = 1'b0;
        if (STRICT_ALIGN != 0) begin
            case (req_size_s)
                SZ_H:    align_err_s = req_addr[0];
                SZ_W:    align_err_s = req_addr[1:0] != 2'b00;
                default: align_err_s = 1'b0;
            endcase
        end else begin
            align_err_s = 1'b0;
        end
        fault_s = range_err_s || align_err_s || (req_size_s == SZ_RSVD);
    end

    lsu_load_extend u_extend (
        .size        (size_r),
        .is_unsigned (uns_r),
        .rdata       (mem_rdata),
        .result      (ext_s)
    );

    // Request FSM, read-latency counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= '0;
            size_r       <= SZ_B;
            uns_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_raddr_r  <= 32'd0;
            mem_waddr_r  <= 32'd0;
            mem_wdata_r  <= 32'd0;
            mem_wr_r     <= WR_NONE;
        end else begin
            // Response and write strobes are single-cycle pulses by default.
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_wr_r     <= WR_NONE;
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        if (fault_s) begin
                            state_r      <= RESP;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else if (req_we) begin
                            state_r     <= STORE;
                            mem_waddr_r <= req_addr;
                            mem_wdata_r <= req_wdata;
                            mem_wr_r    <= lane_mask(req_size_s);
                        end else begin
                            state_r     <= LOAD_WAIT;
                            mem_raddr_r <= req_addr;
                            cnt_r       <= CNT_W'(RD_LAT);
                            size_r      <= req_size_s;
                            uns_r       <= req_unsigned;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                STORE: begin
                    state_r      <= RESP;
                    resp_valid_r <= 1'b1;
                end
                LOAD_WAIT: begin
                    if (cnt_r == '0) begin
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        resp_rdata_r <= ext_s;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;
    assign mem_raddr  = mem_raddr_r;
    assign mem_waddr  = mem_waddr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_wr     = mem_wr_r;

endmodule
